// File: rtl/cpu_run_ctrl.sv
// CPU run controller: halt / free-run / single-step strobe generation.
// Optional BREAKPOINT_EN adds a breakpoint halt on prescaler expiry.
module cpu_run_ctrl #(
  parameter int DIV_W  = 24,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_btn,
  input  logic              step_btn,
  input  logic [DIV_W-1:0]  div_sel,
  input  logic [ADDR_W-1:0] ip,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
  output logic              step_en,
  output logic              running,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  step_cnt
);

  typedef enum logic [1:0] {
    S_HALT,
    S_STEP,
    S_RUN
  } state_t;

  state_t             r_state;
  logic [2:0]         r_run_sy;
  logic [2:0]         r_step_sy;
  logic [DIV_W-1:0]   r_presc;
  logic               r_first;
  logic               r_run_pend;

  logic               w_run_p;
  logic               w_step_p;
  logic               w_bp_match;

  // bit0/bit1 synchronize, bit2 delays for edge detect
  assign w_run_p  = r_run_sy[1] & ~r_run_sy[2];
  assign w_step_p = r_step_sy[1] & ~r_step_sy[2];

`ifdef BREAKPOINT_EN
  assign w_bp_match = bp_valid && (ip == bp_addr) && !r_first;
`else
  logic w_unused;
  assign w_unused   = ^{bp_addr, bp_valid, ip, r_first};
  assign w_bp_match = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HALT;
      r_run_sy   <= '0;
      r_step_sy  <= '0;
      r_presc    <= '0;
      r_first    <= 1'b0;
      r_run_pend <= 1'b0;
      step_en    <= 1'b0;
      running    <= 1'b0;
      bp_hit     <= 1'b0;
      step_cnt   <= '0;
    end else begin
      r_run_sy  <= {r_run_sy[1:0], run_btn};
      r_step_sy <= {r_step_sy[1:0], step_btn};
      step_en   <= 1'b0;
      unique case (r_state)
        S_HALT: begin
          if (w_run_p || r_run_pend) begin
            r_state    <= S_RUN;
            running    <= 1'b1;
            r_presc    <= div_sel;
            bp_hit     <= 1'b0;
            r_first    <= 1'b1;
            r_run_pend <= 1'b0;
          end else if (w_step_p) begin
            r_state  <= S_STEP;
            step_en  <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        S_STEP: begin
          r_state    <= S_HALT;
          r_run_pend <= w_run_p;
        end
        S_RUN: begin
          if (w_run_p) begin
            r_state <= S_HALT;
            running <= 1'b0;
          end else if (r_presc == '0) begin
            if (w_bp_match) begin
              r_state <= S_HALT;
              running <= 1'b0;
              bp_hit  <= 1'b1;
            end else begin
              step_en  <= 1'b1;
              step_cnt <= step_cnt + CNT_W'(1);
              r_presc  <= div_sel;
              r_first  <= 1'b0;
            end
          end else begin
            r_presc <= r_presc - DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_HALT;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with a time-based reference model.
// Build with +define+BREAKPOINT_EN to cover the breakpoint feature.
module tb_cpu_run_ctrl;
  localparam int DIV_W  = 24;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_btn = 1'b0;
  logic              step_btn = 1'b0;
  logic [DIV_W-1:0]  div_sel = '0;
  logic [ADDR_W-1:0] ip = '0;
  logic [ADDR_W-1:0] bp_addr = '0;
  logic              bp_valid = 1'b0;
  logic              step_en;
  logic              running;
  logic              bp_hit;
  logic [CNT_W-1:0]  step_cnt;

  cpu_run_ctrl #(
    .DIV_W(DIV_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .run_btn(run_btn), .step_btn(step_btn),
    .div_sel(div_sel), .ip(ip),
    .bp_addr(bp_addr), .bp_valid(bp_valid),
    .step_en(step_en), .running(running),
    .bp_hit(bp_hit), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: button samples per cycle, mode, next expiry time.
  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  bit   run_h[int];
  bit   step_h[int];
  int   cyc = 0;
  int   rst_last = 0;
  int   m_mode = 0;
  bit   m_pend, m_first, m_bp, m_rp, m_sp, m_hit;
  int   m_next, m_cnt;
  int   last_se = -1;

  function automatic bit h_run(int k);
    return (k > rst_last && run_h.exists(k)) ? run_h[k] : 1'b0;
  endfunction

  function automatic bit h_step(int k);
    return (k > rst_last && step_h.exists(k)) ? step_h[k] : 1'b0;
  endfunction

  function automatic void issue();
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    sb.push_back('{cyc, m_cnt});
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      rst_last = cyc;
      m_mode = 0; m_pend = 0; m_first = 0;
      m_bp = 0; m_cnt = 0;
      sb.delete();
    end else begin
      run_h[cyc]  = run_btn;
      step_h[cyc] = step_btn;
      m_rp = h_run(cyc - 2) && !h_run(cyc - 3);
      m_sp = h_step(cyc - 2) && !h_step(cyc - 3);
      case (m_mode)
        0: begin
          if (m_rp || m_pend) begin
            m_mode = 2; m_bp = 0; m_first = 1; m_pend = 0;
            m_next = cyc + int'(div_sel) + 1;
          end else if (m_sp) begin
            m_mode = 1;
            issue();
          end
        end
        1: begin
          m_mode = 0;
          m_pend = m_rp;
        end
        default: begin
          if (m_rp) m_mode = 0;
          else if (cyc == m_next) begin
            m_hit = 1'b0;
`ifdef BREAKPOINT_EN
            m_hit = bp_valid && (ip == bp_addr) && !m_first;
`endif
            if (m_hit) begin
              m_mode = 0; m_bp = 1;
            end else begin
              issue();
              m_first = 0;
              m_next = cyc + int'(div_sel) + 1;
            end
          end
        end
      endcase
    end
  end

  // CPU stand-in: instruction pointer advances once per step strobe
  always @(negedge clk) begin
    if (!rst_n) ip = '0;
    else if (step_en) ip = ip + 1'b1;
  end

  // Monitor: pop expected strobes and compare every observable output
  always @(negedge clk) begin
    if (rst_n) begin
      bit   exp_se;
      exp_t e;
      exp_se = (sb.size() > 0) && (sb[0].cyc == cyc);
      tests++;
      if (step_en !== exp_se) begin
        fails++;
        $display("FAIL step_en cyc=%0d got=%b exp=%b", cyc, step_en, exp_se);
      end
      if (exp_se) e = sb.pop_front();
      while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
      if (step_en) last_se = cyc;
      tests++;
      if (step_cnt !== CNT_W'(m_cnt)) begin
        fails++;
        $display("FAIL step_cnt cyc=%0d got=%0d exp=%0d", cyc, step_cnt, m_cnt);
      end
      tests++;
      if (running !== (m_mode == 2)) begin
        fails++;
        $display("FAIL running cyc=%0d got=%b exp=%b", cyc, running, m_mode == 2);
      end
      tests++;
      if (bp_hit !== m_bp) begin
        fails++;
        $display("FAIL bp_hit cyc=%0d got=%b exp=%b", cyc, bp_hit, m_bp);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic press(input bit r, input bit s, input int hold);
    @(negedge clk);
    run_btn = r;
    step_btn = s;
    repeat (hold) @(negedge clk);
    run_btn = 1'b0;
    step_btn = 1'b0;
  endtask

  task automatic wait_cnt(input string n, input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (step_cnt == CNT_W'(target)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(n, 32'(ok), 32'd1);
  endtask

  task automatic wait_halt(input string n, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!running) begin
        ok = 1'b1;
        break;
      end
    end
    chk(n, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, cs;
    repeat (3) @(negedge clk);
    chk("rst_step_en", 32'(step_en), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_bp_hit", 32'(bp_hit), 0);
    chk("rst_step_cnt", 32'(step_cnt), 0);
    rst_n = 1'b1;

    // held step button: one strobe on the 3rd sampling edge
    repeat (2) @(negedge clk);
    step_btn = 1'b1;
    c0 = cyc + 1;
    repeat (20) @(negedge clk);
    step_btn = 1'b0;
    repeat (5) @(negedge clk);
    chk("step_latency", 32'(last_se), 32'(c0 + 2));
    chk("step_cnt_1", 32'(step_cnt), 1);
    chk("step_running", 32'(running), 0);

    // free run at div_sel=3
    div_sel = 3;
    press(1, 0, 4);
    wait_cnt("run_ten_steps", 11, 200);
    chk("run_running", 32'(running), 1);
    press(1, 0, 2);
    repeat (6) @(negedge clk);
    chk("halt_running", 32'(running), 0);
    cs = int'(step_cnt);
    repeat (30) @(negedge clk);
    chk("halt_no_steps", 32'(step_cnt), 32'(cs));

    // run and step together: run wins
    press(1, 1, 3);
    repeat (5) @(negedge clk);
    chk("both_running", 32'(running), 1);
    press(1, 0, 2);
    wait_halt("both_halt", 20);

    // randomized mix of buttons, rates and breakpoints
    for (int it = 0; it < 400; it++) begin
      int act;
      div_sel  = DIV_W'($urandom_range(0, 4));
      bp_valid = 1'($urandom_range(0, 1));
      bp_addr  = ADDR_W'($urandom);
      act = $urandom_range(0, 3);
      case (act)
        0: press(1, 0, $urandom_range(1, 4));
        1: press(0, 1, $urandom_range(1, 4));
        2: press(1, 1, $urandom_range(1, 3));
        default: begin
          @(negedge clk);
          step_btn = 1'b1;
          @(negedge clk);
          run_btn = 1'b1;
          repeat (2) @(negedge clk);
          run_btn = 1'b0;
          step_btn = 1'b0;
        end
      endcase
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    for (int k = 0; k < 6 && running; k++) begin
      press(1, 0, 1);
      repeat (6) @(negedge clk);
    end
    chk("rand_halted", 32'(running), 0);

    // breakpoint at ip=5
    do_reset();
    bp_addr = 5;
    bp_valid = 1'b1;
    div_sel = 2;
    press(1, 0, 2);
`ifdef BREAKPOINT_EN
    wait_halt("bp_halt", 200);
    chk("bp_ip", 32'(ip), 5);
    chk("bp_hit_set", 32'(bp_hit), 1);
    chk("bp_step_cnt", 32'(step_cnt), 5);
    press(1, 0, 2);
    wait_cnt("bp_resume", 6, 100);
    repeat (2) @(negedge clk);
    chk("bp_hit_clr", 32'(bp_hit), 0);
    chk("bp_resume_ip", 32'(ip), 6);
    bp_valid = 1'b0;
    press(1, 0, 2);
    wait_halt("bp_stop", 20);
`else
    repeat (60) @(negedge clk);
    chk("nobp_hit", 32'(bp_hit), 0);
    chk("nobp_running", 32'(running), 1);
    press(1, 0, 2);
    wait_halt("nobp_stop", 20);
`endif

    // asynchronous reset while strobing continuously
    bp_valid = 1'b0;
    div_sel = 0;
    press(1, 0, 2);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_step_en", 32'(step_en), 1);
    rst_n = 1'b0;
    #1;
    chk("async_step_en", 32'(step_en), 0);
    chk("async_running", 32'(running), 0);
    chk("async_step_cnt", 32'(step_cnt), 0);
    chk("async_bp_hit", 32'(bp_hit), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // counter wrap with div_sel=0
    div_sel = 0;
    press(1, 0, 2);
    wait_cnt("wrap_reach_max", 32'hFFFF, 70000);
    @(negedge clk);
    chk("wrap_zero", 32'(step_cnt), 0);
    press(1, 0, 2);
    wait_halt("wrap_halt", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequences CPU execution by generating the one-cycle `step_en` strobe that gates the register-write stage (IP, A/B, OUT update).
- Provides halt, free-run at a programmable divided rate, and single-step from the board buttons.
- Sits between the board I/O (buttons, switches) and the control bus that feeds the CPU register-update logic.

Parameters:
- DIV_W, 24, width of the run-rate prescaler and of `div_sel`.
- ADDR_W, 4, width of the instruction pointer and breakpoint address.
- CNT_W, 16, width of the executed-step counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_btn  in  1  raw run/halt toggle button; asynchronous, active-high.
- step_btn  in  1  raw single-step button; asynchronous, active-high.
- div_sel  in  DIV_W  prescaler reload value; step period in RUN is div_sel+1 cycles.
- ip  in  ADDR_W  current CPU instruction pointer.
- bp_addr  in  ADDR_W  breakpoint address.
- bp_valid  in  1  breakpoint armed.
- step_en  out  1  registered one-cycle write-enable strobe to the CPU register stage.
- running  out  1  high while in RUN.
- bp_hit  out  1  sticky: halted by breakpoint.
- step_cnt  out  CNT_W  count of issued step_en pulses.

Behaviour:
- Reset (rst_n=0, async): state=HALT; step_en=0, running=0, bp_hit=0, step_cnt=0, prescaler=0, synchronizers=0.
- Button input path:
  - Each button passes through a 2-FF synchronizer plus a third delay flop.
  - pulse = s2 & ~s3 (rising edge only); holding a button gives one pulse.
- Latency: step_en rises on the 3rd rising edge counting the first edge that samples step_btn=1.
- States HALT, STEP, RUN; state is registered.
- HALT:
  - run pulse -> RUN; prescaler loaded with div_sel; bp_hit cleared; first-step flag set.
  - Otherwise, step pulse -> STEP.
  - Run and step pulses in the same cycle: run wins, step is dropped.
- STEP:
  - Exactly one cycle; step_en=1 in the following cycle; next state HALT.
  - A run pulse arriving while in STEP is honoured on the return to HALT (latched one cycle).
- RUN:
  - running=1; prescaler decrements each cycle.
  - At 0: step_en=1 next cycle, prescaler reloads div_sel, first-step flag cleared.
  - div_sel=0 gives step_en every cycle.
  - div_sel changes take effect at the next reload only.
  - run pulse -> HALT immediately; a pending expiry in that same cycle is suppressed (no step_en).
  - step pulses are ignored in RUN.
- step_en:
  - Never high for two consecutive cycles, except in RUN with div_sel=0.
  - Never asserted while in HALT without a preceding STEP.
- step_cnt increments on every cycle step_en=1 and wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: immediate return to reset values, including a step_en that is currently high.

Optional Feature:
- Macro BREAKPOINT_EN.
- Defined:
  - In RUN at prescaler expiry, if bp_valid=1, ip==bp_addr and the first-step flag is clear: no step_en is issued, state -> HALT, bp_hit=1.
  - bp_hit stays set until the next run pulse.
  - The first step after entering RUN ignores the breakpoint, so execution resumes from a breakpoint address.
  - Single-step never checks the breakpoint.
- Not defined: bp_addr and bp_valid are ignored and bp_hit is tied 0.

Test Plan:
- Reset, then step_btn held high 20 cycles: step_en=1 for exactly one cycle, on the 3rd edge after the first sample; step_cnt=1; running=0.
- run_btn pulse with div_sel=3: running=1; step_en every 4 cycles; after 10 pulses step_cnt=10; a second run_btn pulse -> running=0 and no further step_en.
- div_sel=0 in RUN: step_en continuous high; preset step_cnt near wrap -> 0xFFFF then 0x0000.
- run_btn and step_btn rising on the same cycle in HALT: enters RUN; no extra single-step pulse.
- BREAKPOINT_EN, bp_addr=5, bp_valid=1, ip advancing 0,1,2,... per step: halts with ip=5, bp_hit=1, step_cnt=5. Next run pulse: bp_hit=0, first step issued at ip=5.
- rst_n asserted while in RUN with step_en high: all outputs 0 immediately, without waiting for a clock edge.
